// File: rtl/online_pkg.sv
// Shared definitions for the online arithmetic datapath: signed-digit
// encodings, converter state encoding and a digit decoder.
package online_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Returns {nonzero, negative}; both 2'b00 and 2'b11 decode as zero.
  function automatic logic [1:0] sd_decode(input logic [1:0] d);
    return {d[1] ^ d[0], d[0] & ~d[1]};
  endfunction

endpackage

// File: rtl/online_otf_step.sv
// One radix-2 on-the-fly conversion step: appends a signed digit to the
// Q/QM register pair (QM is always Q-1), shifting both left by one.
module online_otf_step
  import online_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  logic [1:0]   dec;
  logic [W-1:0] q_sh;
  logic [W-1:0] qm_sh;

  always_comb begin
    dec     = sd_decode(digit);
    q_sh    = q << 1;
    qm_sh   = qm << 1;
    q_next  = q_sh;
    qm_next = qm_sh | W'(1);
    if (dec[1] && dec[0]) begin
      // A -1 digit borrows: the new Q comes from the old QM.
      q_next  = qm_sh | W'(1);
      qm_next = qm_sh;
    end else if (dec[1]) begin
      q_next  = q_sh | W'(1);
      qm_next = q_sh;
    end
  end

endmodule

// File: rtl/online_otf_convert.sv
// Digit-serial MSD-first signed-digit to two's-complement converter.
// Optional early sign outputs under ONLINE_OTF_EARLY_SIGN_EN.
module online_otf_convert
  import online_pkg::*;
#(
  parameter int NDIG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_digit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NDIG:0]   result,
`ifdef ONLINE_OTF_EARLY_SIGN_EN
  output logic            sign_valid,
  output logic            sign,
`endif
  output state_t          state
);

  // Handshake: a digit moves on a rising edge with in_valid & in_ready; the
  // result moves with out_valid & out_ready; abort overrides both.
  localparam int W  = NDIG + 1;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  logic [W-1:0]  q;
  logic [W-1:0]  qm;
  logic [W-1:0]  q_next;
  logic [W-1:0]  qm_next;
  logic [CW-1:0] count;
  logic          xfer;

  assign xfer   = in_valid && in_ready && (state != DONE);
  assign result = q;

  online_otf_step #(.W(W)) u_step (
    .q       (q),
    .qm      (qm),
    .digit   (in_digit),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      qm        <= '1;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      q         <= '0;
      qm        <= '1;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (xfer) begin
            q  <= q_next;
            qm <= qm_next;
            if (count == LAST) begin
              state     <= DONE;
              count     <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            q         <= '0;
            qm        <= '1;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ONLINE_OTF_EARLY_SIGN_EN
  logic [1:0] dec;
  assign dec = sd_decode(in_digit);

  // The first nonzero digit fixes the sign of the whole word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_valid <= 1'b0;
      sign       <= 1'b0;
    end else if (abort || (state == DONE && out_ready)) begin
      sign_valid <= 1'b0;
      sign       <= 1'b0;
    end else if (xfer && !sign_valid) begin
      if (dec[1]) begin
        sign_valid <= 1'b1;
        sign       <= dec[0];
      end else if (count == LAST) begin
        sign_valid <= 1'b1;
        sign       <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_online_otf_convert.sv
// Bench for online_otf_convert (NDIG=8): vector table, randomized words
// against an arithmetic model, and hand-written handshake/abort/reset cases.
module tb_online_otf_convert;
  import online_pkg::*;

  localparam int NDIG = 8;

  logic            clk;
  logic            rst_n;
  logic            abort;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_digit;
  logic            out_valid;
  logic            out_ready;
  logic [NDIG:0]   result;
  state_t          st;
`ifdef ONLINE_OTF_EARLY_SIGN_EN
  logic            sign_valid;
  logic            sign;
`endif

  int errors = 0;
  int checks = 0;

  online_otf_convert #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef ONLINE_OTF_EARLY_SIGN_EN
    .sign_valid(sign_valid),
    .sign      (sign),
`endif
    .state     (st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // QM must track Q-1 on every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dut.qm !== 9'(dut.q - 9'd1)) begin
        errors++;
        $display("FAIL qm_invariant: q=%0h qm=%0h", dut.q, dut.qm);
      end
    end
  end

  typedef struct {
    logic [15:0] codes;
    logic [8:0]  exp;
  } vec_t;

  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: digit value sum scaled by 2^NDIG, wrapped to NDIG+1 bits.
  function automatic logic [8:0] ref_value(input logic [15:0] codes);
    int v;
    logic [1:0] c;
    int tmp;
    v = 0;
    for (int i = 0; i < NDIG; i++) begin
      c = codes[15 - 2*i -: 2];
      tmp = (c == 2'b10) ? 1 : (c == 2'b01) ? -1 : 0;
      v += tmp * (1 << (NDIG - 1 - i));
    end
    tmp = v;
    return tmp[8:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [1:0] code);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_digit = code;
    while (!acc && n < 20) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_digit = 2'b00;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck low");
    end
  endtask

  // Sends a full word; checks out_valid stays low until the last transfer.
  task automatic send_word(input logic [15:0] codes, input int gap_max);
    for (int i = 0; i < NDIG; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      if (i == NDIG - 1) check("early_out_valid", out_valid, 0);
      send_digit(codes[15 - 2*i -: 2]);
    end
  endtask

  task automatic check_done();
    logic [8:0] e;
    e = exp_q.pop_front();
    check("latency_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    check("result", result, e);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("accept_out_valid", out_valid, 0);
    check("accept_in_ready", in_ready, 1);
    check("accept_state", st, IDLE);
  endtask

  task automatic run_word(input logic [15:0] codes, input logic [8:0] exp, input int gap_max);
    exp_q.push_back(exp);
    send_word(codes, gap_max);
    check_done();
    accept();
  endtask

  vec_t vecs[6];

  initial begin
    logic [15:0] codes;

    vecs[0] = '{16'h8000, 9'h080};
    vecs[1] = '{16'h6000, 9'h1C0};
    vecs[2] = '{16'hAAAA, 9'h0FF};
    vecs[3] = '{16'h5555, 9'h101};
    vecs[4] = '{16'hFFFF, 9'h000};
    vecs[5] = '{16'h9000, 9'h040};

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_digit = 2'b00; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_state", st, IDLE);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // table-driven vectors, with a model cross-check of each expectation
    for (int i = 0; i < 6; i++) begin
      check("model_vs_table", ref_value(vecs[i].codes), vecs[i].exp);
      run_word(vecs[i].codes, vecs[i].exp, 0);
    end

    // random words with input gaps
    for (int i = 0; i < 20; i++) begin
      codes = 16'($urandom);
      run_word(codes, ref_value(codes), 2);
    end

    // backpressure: result held for 5 cycles
    exp_q.push_back(9'h0FF);
    send_word(16'hAAAA, 0);
    check_done();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 9'h0FF);
    end
    accept();
    run_word(16'h5555, 9'h101, 1);

    // asynchronous reset mid-word
    for (int i = 0; i < 3; i++) send_digit(2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", result, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_state", st, IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    run_word(16'h8000, 9'h080, 0);

    // abort after 5 digits; the digit offered alongside abort is dropped
    for (int i = 0; i < 5; i++) send_digit(2'b01);
    abort = 1'b1; in_valid = 1'b1; in_digit = 2'b10;
    tick();
    abort = 1'b0; in_valid = 1'b0; in_digit = 2'b00;
    check("abort_state", st, IDLE);
    check("abort_result", result, 0);
    check("abort_in_ready", in_ready, 1);
    run_word(16'h8000, 9'h080, 0);

    // abort in DONE discards the result
    exp_q.push_back(9'h0FF);
    send_word(16'hAAAA, 0);
    check_done();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_out_valid", out_valid, 0);
    check("abort_done_state", st, IDLE);
    run_word(16'h9000, 9'h040, 0);

`ifdef ONLINE_OTF_EARLY_SIGN_EN
    // 0,0,-1,+1,0,... : sign fixed one cycle after the 3rd transfer
    send_digit(2'b00);
    send_digit(2'b00);
    check("sign_valid_early", sign_valid, 0);
    send_digit(2'b01);
    check("sign_valid_3rd", sign_valid, 1);
    check("sign_3rd", sign, 1);
    send_digit(2'b10);
    for (int i = 0; i < 4; i++) send_digit(2'b00);
    exp_q.push_back(9'h1F0);
    check_done();
    accept();
    check("sign_valid_clear", sign_valid, 0);
    // all-zero word: sign_valid rises with out_valid
    for (int i = 0; i < NDIG - 1; i++) send_digit(2'b00);
    check("zero_sign_valid_pre", sign_valid, 0);
    send_digit(2'b11);
    check("zero_sign_valid", sign_valid, 1);
    check("zero_sign", sign, 0);
    exp_q.push_back(9'h000);
    check_done();
    accept();
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
